// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester handshakes and the shared memory port.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_flush;
    logic            i_ack;
    logic [XLEN-1:0] i_rdata;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_ack;
    logic [XLEN-1:0] d_rdata;

    logic            mem_sel;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata,
               mem_ready, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
               mem_sel, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata,
               mem_ready, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
               mem_sel, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and data access,
// one transaction in flight, with a starvation bound on fetch.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DRAIN_I} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t          state;
    state_t          state_nxt;
    logic            sel_q;
    logic            we_q;
    logic [3:0]      starve_cnt;
    logic            force_i;
    logic            grant_i;
    logic            grant_d;
    logic [XLEN-1:0] addr_mux;
    logic [XLEN-1:0] wdata_mux;

    assign force_i = (starve_cnt == LIMIT) && bus.i_req;

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.d_req && !force_i) begin
                    state_nxt = GRANT_D;
                    grant_d   = 1'b1;
                end else if (bus.i_req && !bus.i_flush) begin
                    state_nxt = GRANT_I;
                    grant_i   = 1'b1;
                end
            end
            // Memory cannot abort, so a flushed fetch is drained rather than dropped.
            GRANT_I: begin
                if (bus.mem_ready)     state_nxt = IDLE;
                else if (bus.i_flush)  state_nxt = DRAIN_I;
            end
            GRANT_D, DRAIN_I: begin
                if (bus.mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Select and write enable are latched at grant; write enable drops once idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 1'b0;
            we_q  <= 1'b0;
        end else if (grant_d) begin
            sel_q <= 1'b1;
            we_q  <= bus.d_we;
        end else if (grant_i) begin
            sel_q <= 1'b0;
            we_q  <= 1'b0;
        end else if (state_nxt == IDLE) begin
            we_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                starve_cnt <= 4'd0;
        else if (!bus.i_req || grant_i)            starve_cnt <= 4'd0;
        else if (grant_d && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + 4'd1;
    end

    assign addr_mux  = sel_q ? bus.d_addr  : bus.i_addr;
    assign wdata_mux = sel_q ? bus.d_wdata : '0;

    assign bus.mem_req   = (state != IDLE);
    assign bus.mem_sel   = sel_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

    assign bus.i_ack   = (state == GRANT_I) && bus.mem_ready && !bus.i_flush;
    assign bus.d_ack   = (state == GRANT_D) && bus.mem_ready;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory responder model plus a scoreboard of
// expected port transactions, with per-scenario tasks.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   mem_wait;
    logic [31:0] rdata_val;
    bit   mon_en;

    typedef struct {
        logic        sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
    } exp_t;

    exp_t sb[$];

    mem_port_arbiter_if #(.XLEN(32)) bus ();

    mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic sel, logic we, logic [31:0] addr, logic [31:0] wdata, logic ack);
        exp_t e;
        e.sel = sel; e.we = we; e.addr = addr; e.wdata = wdata; e.ack = ack;
        return e;
    endfunction

    // Memory model: mem_ready after mem_wait extra cycles of mem_req.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cnt = 0;
                bus.mem_ready = 1'b0;
            end else if (bus.mem_req && !bus.mem_ready) begin
                if (cnt >= mem_wait) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rdata_val;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                bus.mem_ready = 1'b0;
            end
        end
    end

    // Scoreboard: every completed port transaction is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bus.mem_req && bus.mem_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_txn: addr=%h with no expected transaction", bus.mem_addr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    if (bus.mem_sel !== e.sel) begin
                        errors++;
                        $display("FAIL sb_sel: got %b want %b", bus.mem_sel, e.sel);
                    end
                    checks++;
                    if (bus.mem_we !== e.we) begin
                        errors++;
                        $display("FAIL sb_we: got %b want %b", bus.mem_we, e.we);
                    end
                    checks++;
                    if (bus.mem_addr !== e.addr) begin
                        errors++;
                        $display("FAIL sb_addr: got %h want %h", bus.mem_addr, e.addr);
                    end
                    if (e.sel) begin
                        checks++;
                        if (bus.mem_wdata !== e.wdata) begin
                            errors++;
                            $display("FAIL sb_wdata: got %h want %h", bus.mem_wdata, e.wdata);
                        end
                    end
                    checks++;
                    if (bus.i_ack !== (!e.sel && e.ack) || bus.d_ack !== (e.sel && e.ack)) begin
                        errors++;
                        $display("FAIL sb_ack: got i=%b d=%b want i=%b d=%b",
                                 bus.i_ack, bus.d_ack, !e.sel && e.ack, e.sel && e.ack);
                    end
                    checks++;
                    if (bus.i_rdata !== bus.mem_rdata || bus.d_rdata !== bus.mem_rdata) begin
                        errors++;
                        $display("FAIL sb_rdata: got i=%h d=%h want %h", bus.i_rdata, bus.d_rdata, bus.mem_rdata);
                    end
                end
            end else if (bus.i_ack || bus.d_ack) begin
                checks++;
                errors++;
                $display("FAIL stray_ack: got i=%b d=%b want 0 0 without mem_ready", bus.i_ack, bus.d_ack);
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        int g;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_sel, bus.mem_we, bus.i_ack, bus.d_ack} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {bus.mem_req, bus.mem_sel, bus.mem_we, bus.i_ack, bus.d_ack});
        end
        drive_edge();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        mem_wait = 5;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300; bus.d_wdata = 32'h77;
        sb.push_back(mk(1'b1, 1'b1, 32'h300, 32'h77, 1'b1));
        g = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                g = c;
                break;
            end
            drive_edge();
        end
        checks++;
        if (g < 0 || bus.mem_sel !== 1'b1 || bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_grant: got g=%0d sel=%b we=%b want grant with sel=1 we=1", g, bus.mem_sel, bus.mem_we);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_sel, bus.mem_we, bus.i_ack, bus.d_ack} !== 5'b0) begin
            errors++;
            $display("FAIL reset_async: got %b want 00000",
                     {bus.mem_req, bus.mem_sel, bus.mem_we, bus.i_ack, bus.d_ack});
        end
        sb.delete();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        drive_edge();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_req !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_req: cycle %0d got %b want 0", c, bus.mem_req);
            end
        end
        drive_edge();
    endtask

    task automatic test_fetch();
        int req_cyc, ack_cyc, n_i, n_d;
        mem_wait  = 2;
        rdata_val = 32'hDEADBEEF;
        sb.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 1'b1));
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        req_cyc = -1; ack_cyc = -1; n_i = 0; n_d = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.mem_req && req_cyc < 0) begin
                req_cyc = c;
                checks++;
                if (bus.mem_sel !== 1'b0 || bus.mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_sel_we: got sel=%b we=%b want 0 0", bus.mem_sel, bus.mem_we);
                end
            end
            if (bus.i_ack) begin
                n_i++;
                ack_cyc = c;
                checks++;
                if (bus.i_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL fetch_rdata: got %h want deadbeef", bus.i_rdata);
                end
            end
            if (bus.d_ack) n_d++;
            drive_edge();
            if (ack_cyc == c) bus.i_req = 1'b0;
        end
        checks++;
        if (n_i != 1 || n_d != 0) begin
            errors++;
            $display("FAIL fetch_ack_count: got i=%0d d=%0d want 1 0", n_i, n_d);
        end
        checks++;
        if (req_cyc != 1 || ack_cyc != 3) begin
            errors++;
            $display("FAIL fetch_latency: got req@%0d ack@%0d want req@1 ack@3", req_cyc, ack_cyc);
        end
    endtask

    task automatic test_simul();
        int d_cyc, i_cyc;
        mem_wait  = 0;
        rdata_val = 32'h0BADF00D;
        sb.push_back(mk(1'b1, 1'b1, 32'h2000, 32'h55AA, 1'b1));
        sb.push_back(mk(1'b0, 1'b0, 32'h400, 32'h0, 1'b1));
        bus.i_req = 1'b1; bus.i_addr = 32'h400;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'h55AA;
        d_cyc = -1; i_cyc = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.d_ack && d_cyc < 0) begin
                d_cyc = c;
                checks++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h2000 || bus.mem_wdata !== 32'h55AA) begin
                    errors++;
                    $display("FAIL simul_store: got we=%b addr=%h wdata=%h want 1 2000 55aa",
                             bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end
            if (bus.i_ack && i_cyc < 0) i_cyc = c;
            drive_edge();
            if (d_cyc == c) begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
            if (i_cyc == c) bus.i_req = 1'b0;
        end
        checks++;
        if (d_cyc != 1 || i_cyc != 3) begin
            errors++;
            $display("FAIL simul_order: got d@%0d i@%0d want d@1 i@3", d_cyc, i_cyc);
        end
    endtask

    task automatic test_starve();
        int seq[$];
        int n_d, i_cyc;
        int want[6] = '{1, 1, 1, 1, 0, 1};
        mem_wait  = 0;
        rdata_val = 32'h12345678;
        for (int k = 0; k < 4; k++) sb.push_back(mk(1'b1, 1'b0, 32'h600, 32'h1234, 1'b1));
        sb.push_back(mk(1'b0, 1'b0, 32'h500, 32'h0, 1'b1));
        sb.push_back(mk(1'b1, 1'b0, 32'h600, 32'h1234, 1'b1));
        bus.i_req = 1'b1; bus.i_addr = 32'h500;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600; bus.d_wdata = 32'h1234;
        n_d = 0; i_cyc = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 8) begin
                checks++;
                if (dut.starve_cnt !== 4'd4) begin
                    errors++;
                    $display("FAIL starve_cnt_limit: got %0d want 4", dut.starve_cnt);
                end
            end
            if (bus.d_ack) begin seq.push_back(1); n_d++; end
            if (bus.i_ack) begin seq.push_back(0); i_cyc = c; end
            drive_edge();
            if (i_cyc == c) bus.i_req = 1'b0;
            if (n_d == 5) bus.d_req = 1'b0;
        end
        checks++;
        if (seq.size() != 6) begin
            errors++;
            $display("FAIL starve_ack_count: got %0d want 6", seq.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (seq[k] != want[k]) begin
                    errors++;
                    $display("FAIL starve_seq[%0d]: got %0d want %0d (1=D 0=I)", k, seq[k], want[k]);
                end
            end
        end
        checks++;
        if (i_cyc != 9) begin
            errors++;
            $display("FAIL starve_force_cycle: got %0d want 9", i_cyc);
        end
        checks++;
        if (dut.starve_cnt !== 4'd0) begin
            errors++;
            $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt);
        end
    endtask

    task automatic test_flush();
        int g, n_i, rdy_cyc, ack_cyc;
        bit early_drop;
        mem_wait  = 3;
        rdata_val = 32'hCAFE0001;
        sb.push_back(mk(1'b0, 1'b0, 32'h700, 32'h0, 1'b0));
        bus.i_req = 1'b1; bus.i_addr = 32'h700;
        g = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin g = c; break; end
            drive_edge();
        end
        checks++;
        if (g < 0) begin
            errors++;
            $display("FAIL flush_grant_timeout: got no mem_req want grant");
        end
        drive_edge();
        bus.i_flush = 1'b1; bus.i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.i_ack !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: got req=%b ack=%b want 1 0", bus.mem_req, bus.i_ack);
        end
        drive_edge();
        bus.i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (2'(dut.state) !== 2'd3 || bus.mem_req !== 1'b1 || bus.mem_sel !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain_state: got state=%0d req=%b sel=%b want 3 1 0",
                     2'(dut.state), bus.mem_req, bus.mem_sel);
        end
        n_i = 0; rdy_cyc = -1; early_drop = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive_edge();
            @(negedge clk);
            if (bus.i_ack) n_i++;
            if (rdy_cyc < 0) begin
                if (!bus.mem_req) early_drop = 1'b1;
                else if (bus.mem_ready) rdy_cyc = c;
            end
        end
        checks++;
        if (n_i != 0 || early_drop || rdy_cyc != 0) begin
            errors++;
            $display("FAIL flush_drain: got acks=%0d early_drop=%b ready@%0d want 0 0 0", n_i, early_drop, rdy_cyc);
        end
        drive_edge();
        mem_wait = 0;
        sb.push_back(mk(1'b0, 1'b0, 32'h800, 32'h0, 1'b1));
        bus.i_req = 1'b1; bus.i_addr = 32'h800;
        ack_cyc = -1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.i_ack && ack_cyc < 0) ack_cyc = c;
            drive_edge();
            if (ack_cyc == c) bus.i_req = 1'b0;
        end
        checks++;
        if (ack_cyc != 1) begin
            errors++;
            $display("FAIL flush_refetch: got ack@%0d want 1", ack_cyc);
        end
    endtask

    task automatic test_flush_ready();
        int g, d_cyc;
        mem_wait  = 2;
        rdata_val = 32'hA5A5A5A5;
        sb.push_back(mk(1'b0, 1'b0, 32'h900, 32'h0, 1'b0));
        bus.i_req = 1'b1; bus.i_addr = 32'h900;
        g = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin g = c; break; end
            drive_edge();
        end
        checks++;
        if (g < 0) begin
            errors++;
            $display("FAIL flushrdy_grant_timeout: got no mem_req want grant");
        end
        drive_edge();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'hA00; bus.d_wdata = 32'h0;
        sb.push_back(mk(1'b1, 1'b0, 32'hA00, 32'h0, 1'b1));
        @(negedge clk);
        checks++;
        if (bus.mem_sel !== 1'b0 || bus.mem_addr !== 32'h900) begin
            errors++;
            $display("FAIL flushrdy_hold_i: got sel=%b addr=%h want 0 900", bus.mem_sel, bus.mem_addr);
        end
        drive_edge();
        bus.i_flush = 1'b1; bus.i_req = 1'b0;
        mem_wait = 0;
        @(negedge clk);
        checks++;
        if (bus.i_ack !== 1'b0 || bus.mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL flushrdy_suppress: got ack=%b ready=%b want 0 1", bus.i_ack, bus.mem_ready);
        end
        drive_edge();
        bus.i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flushrdy_idle: got mem_req=%b want 0", bus.mem_req);
        end
        d_cyc = -1;
        for (int c = 0; c < 4; c++) begin
            drive_edge();
            if (d_cyc >= 0) bus.d_req = 1'b0;
            @(negedge clk);
            if (bus.d_ack && d_cyc < 0) d_cyc = c;
        end
        bus.d_req = 1'b0;
        checks++;
        if (d_cyc != 0) begin
            errors++;
            $display("FAIL flushrdy_d_grant: got d_ack@%0d want 0", d_cyc);
        end
    endtask

    task automatic test_flush_idle();
        int ack_cyc;
        drive_edge();
        mem_wait  = 0;
        rdata_val = 32'h00C0FFEE;
        sb.push_back(mk(1'b0, 1'b0, 32'hB00, 32'h0, 1'b1));
        bus.i_req = 1'b1; bus.i_addr = 32'hB00; bus.i_flush = 1'b1;
        drive_edge();
        bus.i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flushidle_no_grant: got mem_req=%b want 0", bus.mem_req);
        end
        ack_cyc = -1;
        for (int c = 0; c < 5; c++) begin
            drive_edge();
            if (ack_cyc >= 0) bus.i_req = 1'b0;
            @(negedge clk);
            if (bus.i_ack && ack_cyc < 0) ack_cyc = c;
        end
        bus.i_req = 1'b0;
        checks++;
        if (ack_cyc != 0) begin
            errors++;
            $display("FAIL flushidle_grant: got ack@%0d want 0", ack_cyc);
        end
    endtask

    initial begin
        errors = 0; checks = 0; mon_en = 1'b0;
        mem_wait = 0; rdata_val = 32'h0;
        bus.i_req = 1'b0; bus.i_addr = 32'h0; bus.i_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        test_reset();
        test_fetch();
        test_simul();
        test_starve();
        test_flush();
        test_flush_ready();
        test_flush_idle();
        repeat (3) drive_edge();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the core's single memory port between the instruction-fetch requester (I, read-only) and the data-access requester (D, read/write). It registers a grant, drives the address/write-data select that feeds the port-side Mux2, and sequences one outstanding memory transaction at a time. Fetch flushes are absorbed by draining the in-flight read. A starvation counter bounds how long fetch can be locked out by back-to-back data accesses.

## Interface
- XLEN, 32, address/data width (matches `INST_SIZE)
- STARVE_LIMIT, 4, consecutive D grants with I pending before I is forced; legal range 1..15

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held high with stable i_addr until i_ack
- i_addr  in  XLEN  fetch address
- i_flush  in  1  one-cycle pulse; cancels the current or pending fetch
- i_ack  out  1  one-cycle pulse; i_rdata valid
- i_rdata  out  XLEN  fetch data (mem_rdata passthrough)
- d_req  in  1  data request; held high with stable d_addr/d_we/d_wdata until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_ack  out  1  one-cycle pulse; d_rdata valid for loads
- d_rdata  out  XLEN  load data (mem_rdata passthrough)
- mem_sel  out  1  0 = I side, 1 = D side; drives port-side Mux2 select
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write enable (0 when mem_sel = 0)
- mem_addr  out  XLEN  selected address
- mem_wdata  out  XLEN  selected write data
- mem_ready  in  1  one-cycle completion pulse from memory
- mem_rdata  in  XLEN  read data, valid with mem_ready

## Operation
- States: IDLE, GRANT_I, GRANT_D, DRAIN_I.
- IDLE: mem_req = 0.
  - If d_req and not force_i: go to GRANT_D.
  - Else if i_req and not i_flush: go to GRANT_I.
  - Else stay in IDLE.
  - force_i = (starve_cnt == STARVE_LIMIT) && i_req.
- GRANT_I / GRANT_D: mem_req = 1; mem_sel, mem_we, mem_addr and mem_wdata come from the granted side.
  - On mem_ready: assert the matching ack combinationally in the same cycle and go to IDLE.
- GRANT_I with i_flush and no mem_ready: go to DRAIN_I. Memory cannot abort, so mem_req stays high.
- GRANT_I with i_flush and mem_ready in the same cycle: i_ack is suppressed; go to IDLE.
- DRAIN_I: mem_req = 1, mem_sel = 0. On mem_ready, go to IDLE with i_ack held low.
- i_flush in IDLE: no grant to I that cycle.
- i_flush in GRANT_D: ignored.
- starve_cnt (4 bits, saturating at STARVE_LIMIT):
  - Increments on each IDLE→GRANT_D transition taken while i_req = 1.
  - Clears on any IDLE→GRANT_I transition.
  - Clears in any cycle where i_req = 0.
- mem_sel, mem_we and the granted-side identity are registered at grant. mem_addr and mem_wdata are a combinational mux of the held requester inputs on the registered mem_sel.
- i_rdata = d_rdata = mem_rdata at all times; only the acks qualify them.
- Requesters dropping req before ack is a protocol violation. Behaviour is undefined and not checked.

## Timing
- Reset (rst_n low, asynchronous):
  - State = IDLE, starve_cnt = 0.
  - mem_req = 0, mem_sel = 0, mem_we = 0, i_ack = 0, d_ack = 0.
- Reset mid-transaction abandons the access. Memory shares rst_n.
- Arbitration happens in IDLE. mem_req rises on the next edge.
- Minimum transaction: 2 cycles (grant cycle plus zero-wait mem_ready). Request cycle N gives mem_req at N+1 and ack at N+1. The next grant can be at N+2 and its mem_req at N+3.
- Each added memory wait state adds exactly 1 cycle.
- The ack is combinational from mem_ready and the registered state; there is no extra latency.
- Only one transaction is outstanding at a time. mem_req is never asserted in IDLE.
- Simultaneous d_req and i_req: D wins unless force_i is set.

## Test plan
- Reset with rst_n low mid-GRANT_D (mem_req = 1) → all outputs 0 immediately (asynchronous). After release, state is IDLE with no mem_req until a new request arrives.
- I-only fetch of 0x100, mem_ready 2 cycles after mem_req → mem_sel = 0 and mem_we = 0; i_ack pulses exactly once with i_rdata = mem_rdata (0xDEADBEEF); d_ack never asserts.
- Simultaneous i_req and d_req (store 0x55AA to 0x2000, zero-wait memory) → D granted first with mem_we = 1, mem_addr = 0x2000, mem_wdata = 0x55AA; I granted in the next IDLE and acked 2 cycles later.
- d_req held continuously with i_req pending, STARVE_LIMIT = 4 → exactly 4 D acks, then an I grant, then D resumes and starve_cnt returns to 0.
- i_flush in GRANT_I with mem_ready 3 cycles later → state goes to DRAIN_I; mem_req stays high until mem_ready; i_ack never pulses; a new i_req after the flush is granted from IDLE.
- i_flush coincident with mem_ready in GRANT_I → no i_ack; the next cycle is IDLE; a pending d_req is granted.
